// File: rtl/apb_rst_seq_if.sv
// rtl/apb_rst_seq_if.sv - APB register bus bundle for the reset sequencer
//
// Purpose: groups the APB select/enable/write/address/data signals so the
//          sequencer and its bus master connect through one port.
// Signals:
//   psel, penable, pwrite  APB control, master -> slave
//   paddr   [A_WIDTH-1:0]  APB address, master -> slave
//   pwdata  [D_WIDTH-1:0]  APB write data, master -> slave
//   prdata  [D_WIDTH-1:0]  APB read data, slave -> master
// Modports: master (bus driver), slave (register block).
interface apb_rst_seq_if #(
  parameter int A_WIDTH = 32,
  parameter int D_WIDTH = 32
);
  logic               psel;
  logic               penable;
  logic               pwrite;
  logic [A_WIDTH-1:0] paddr;
  logic [D_WIDTH-1:0] pwdata;
  logic [D_WIDTH-1:0] prdata;

  modport master (
    output psel,
    output penable,
    output pwrite,
    output paddr,
    output pwdata,
    input  prdata
  );

  modport slave (
    input  psel,
    input  penable,
    input  pwrite,
    input  paddr,
    input  pwdata,
    output prdata
  );
endinterface

// File: rtl/apb_rst_seq.sv
// rtl/apb_rst_seq.sv - APB-programmable sequenced release of domain resets
//
// Purpose: synchronises the PMU request sys_rst_n into pclk, then releases
//          N_DOM domain resets one at a time in ascending index order with
//          a programmable gap; re-asserts them all together when sys_rst_n
//          drops. Status and a completed-sequence counter are readable over APB.
// Ports:
//   pclk        APB/system clock
//   presetn     asynchronous active-low reset
//   apb         apb_rst_seq_if.slave register bus (prdata registered)
//   sys_rst_n   PMU reset request, asynchronous to pclk, active-low
//   dom_rst_n   [N_DOM-1:0] registered active-low domain resets
// Registers (paddr[7:0]):
//   0x00 DELAY  [15:0] RW   0x04 STATUS RO   0x08 SEQCNT RO   0x0C CLR WO
//   0x10 MASK   [N_DOM-1:0] RW, present only with APB_RST_SEQ_MASK_EN defined
// Optional feature macro: APB_RST_SEQ_MASK_EN
module apb_rst_seq #(
  parameter int A_WIDTH = 32,
  parameter int D_WIDTH = 32,
  parameter int N_DOM   = 4,
  parameter int DLY_RST = 16
) (
  input  logic             pclk,
  input  logic             presetn,
  apb_rst_seq_if.slave     apb,
  input  logic             sys_rst_n,
  output logic [N_DOM-1:0] dom_rst_n
);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int              IDX_W    = (N_DOM > 1) ? $clog2(N_DOM) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DOM - 1);

  localparam logic [7:0] A_DELAY  = 8'h00;
  localparam logic [7:0] A_STATUS = 8'h04;
  localparam logic [7:0] A_SEQCNT = 8'h08;
  localparam logic [7:0] A_CLR    = 8'h0C;
`ifdef APB_RST_SEQ_MASK_EN
  localparam logic [7:0] A_MASK   = 8'h10;
`endif

  // Two-flop synchroniser; both stages reset low so domains stay held.
  logic sync_q1;
  logic sync_n;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      sync_q1 <= 1'b0;
      sync_n  <= 1'b0;
    end else begin
      sync_q1 <= sys_rst_n;
      sync_n  <= sync_q1;
    end
  end

  logic [7:0] addr;
  logic       wr_en;
  logic       rd_en;
  logic       clr_en;

  assign addr   = apb.paddr[7:0];
  assign wr_en  = apb.psel & apb.penable & apb.pwrite;
  assign rd_en  = apb.psel & ~apb.penable & ~apb.pwrite;
  assign clr_en = wr_en && (addr == A_CLR) && apb.pwdata[0];

  logic        unused_bits;
  assign unused_bits = ^{apb.paddr[A_WIDTH-1:8], apb.pwdata[D_WIDTH-1:16]};

  // DELAY register
  logic [15:0] delay_q;
  logic [15:0] gap_m1;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      delay_q <= 16'(DLY_RST);
    end else if (wr_en && (addr == A_DELAY)) begin
      delay_q <= apb.pwdata[15:0];
    end
  end

  // Reload value for the gap counter: max(DELAY,1) - 1.
  assign gap_m1 = (delay_q == 16'd0) ? 16'd0 : (delay_q - 16'd1);

`ifdef APB_RST_SEQ_MASK_EN
  logic [N_DOM-1:0] mask_q;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      mask_q <= '0;
    end else if (wr_en && (addr == A_MASK)) begin
      mask_q <= apb.pwdata[N_DOM-1:0];
    end
  end
`endif

  // Sequencer
  state_t           state_q;
  logic [15:0]      cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [N_DOM-1:0] dom_q;
  logic             release_now;
  logic             seq_done;

  assign release_now = (state_q == ST_WAIT) && (cnt_q == 16'd0);
  // Qualified by sync_n because an abort in the same cycle suppresses completion.
  assign seq_done    = sync_n && release_now && (idx_q == IDX_LAST);

`ifdef APB_RST_SEQ_MASK_EN
  // Domains already released (index below idx) and the one due now; masking
  // is applied on top so a masked slot still spends its full gap.
  logic [N_DOM-1:0] rel_below;
  logic [N_DOM-1:0] rel_now;

  always_comb begin
    rel_below = '0;
    for (int i = 0; i < N_DOM; i++) begin
      rel_below[i] = (i < int'(idx_q));
    end
    rel_now = rel_below | (N_DOM'(1) << idx_q);
  end
`endif

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= ST_HOLD;
      cnt_q   <= 16'd0;
      idx_q   <= '0;
      dom_q   <= '0;
    end else if (!sync_n) begin
      // Abort beats everything, including a release due this cycle.
      state_q <= ST_HOLD;
      cnt_q   <= 16'd0;
      idx_q   <= '0;
      dom_q   <= '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          dom_q   <= '0;
          cnt_q   <= gap_m1;
          idx_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_q != 16'd0) begin
            cnt_q <= cnt_q - 16'd1;
`ifdef APB_RST_SEQ_MASK_EN
            dom_q <= rel_below & ~mask_q;
`endif
          end else begin
`ifdef APB_RST_SEQ_MASK_EN
            dom_q <= rel_now & ~mask_q;
`else
            dom_q[idx_q] <= 1'b1;
`endif
            if (idx_q == IDX_LAST) begin
              state_q <= ST_DONE;
            end else begin
              idx_q <= idx_q + 1'b1;
              cnt_q <= gap_m1;
            end
          end
        end
        ST_DONE: begin
`ifdef APB_RST_SEQ_MASK_EN
          dom_q <= ~mask_q;
`else
          dom_q <= '1;
`endif
        end
        default: begin
          state_q <= ST_HOLD;
          cnt_q   <= 16'd0;
          idx_q   <= '0;
          dom_q   <= '0;
        end
      endcase
    end
  end

  assign dom_rst_n = dom_q;

  // SEQCNT: a clear in the completion cycle wins.
  logic [31:0] seqcnt_q;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      seqcnt_q <= 32'd0;
    end else if (clr_en) begin
      seqcnt_q <= 32'd0;
    end else if (seq_done) begin
      seqcnt_q <= seqcnt_q + 32'd1;
    end
  end

  // Read path: captured in the setup cycle, held until the next read.
  logic [D_WIDTH-1:0] rd_data;
  logic [D_WIDTH-1:0] prdata_q;

  always_comb begin
    rd_data = '0;
    case (addr)
      A_DELAY:  rd_data[15:0] = delay_q;
      A_STATUS: begin
        rd_data[N_DOM-1:0] = dom_q;
        rd_data[17:16]     = state_q;
        rd_data[24]        = sync_n;
      end
      A_SEQCNT: rd_data[31:0] = seqcnt_q;
`ifdef APB_RST_SEQ_MASK_EN
      A_MASK:   rd_data[N_DOM-1:0] = mask_q;
`endif
      default:  rd_data = '0;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      prdata_q <= '0;
    end else if (rd_en) begin
      prdata_q <= rd_data;
    end
  end

  assign apb.prdata = prdata_q;

endmodule

// File: doc/apb_rst_seq.md
Name: apb_rst_seq

Overview:
- APB-programmable reset sequencer. Sits directly downstream of the PMU and consumes its sys_rst_n output.
- Synchronises sys_rst_n into pclk, then releases N_DOM subsystem resets one at a time in index order, with a programmable gap between releases.
- On sys_rst_n assertion, all domain resets are re-asserted together.
- Provides status and a sequence counter over APB.

Parameters:
- A_WIDTH, 32, APB address width.
- D_WIDTH, 32, APB data width.
- N_DOM, 4, number of sequenced reset domains (1..16).
- DLY_RST, 16, reset value of the DELAY register.

Ports:
- pclk  input  1  APB/system clock.
- presetn  input  1  reset, asynchronous, active-low.
- psel  input  1  APB select.
- paddr  input  A_WIDTH  APB address; only [7:0] decoded.
- pwrite  input  1  APB write.
- pwdata  input  D_WIDTH  APB write data.
- penable  input  1  APB enable.
- prdata  output  D_WIDTH  APB read data, registered.
- sys_rst_n  input  1  request from PMU, asynchronous to pclk, active-low.
- dom_rst_n  output  N_DOM  per-domain resets, active-low, registered.

Behaviour:
- APB write strobe: psel & penable & pwrite, applied at the end of the access phase.
- APB read strobe: psel & !penable & !pwrite. prdata is loaded in the setup cycle and holds until the next read.
- Unmapped addresses: reads return 0, writes are ignored.
- Register map:
  - 0x00 DELAY [15:0], RW, reset DLY_RST. Bits [31:16] read 0.
  - 0x04 STATUS, RO: [N_DOM-1:0] = dom_rst_n; [17:16] = FSM state (HOLD=0, WAIT=1, DONE=2); [24] = synchronised sys_rst_n.
  - 0x08 SEQCNT, RO, reset 0: number of completed sequences, wraps at 2^32.
  - 0x0C CLR, WO: writing bit0=1 clears SEQCNT. Reads return 0.
- Synchroniser: two flops, both reset to 0. sync_n is the second flop.
- Reset values: dom_rst_n=0, prdata=0, state=HOLD, cnt=0, idx=0.
- Effective gap: D = max(DELAY,1), latched at every HOLD->WAIT and at every release.
- FSM:
  - HOLD: dom_rst_n all 0. If sync_n=1: cnt<=D-1, idx<=0, go to WAIT.
  - WAIT: if cnt!=0, decrement cnt. If cnt==0: dom_rst_n[idx]<=1.
    - If idx==N_DOM-1: go to DONE and increment SEQCNT.
    - Otherwise: idx<=idx+1, cnt<=D-1.
  - DONE: outputs held, all 1.
  - Any state with sync_n=0: next cycle dom_rst_n<=0, state<=HOLD, cnt<=0, idx<=0. This overrides all other transitions, including a release due in the same cycle.
- Release timing: with sync_n first high at edge T, dom_rst_n[k] rises at edge T+(k+1)*D. Release order is strictly ascending and never skips an index.
- Assertion latency: sys_rst_n low to all dom_rst_n low in 3 pclk edges at most (2 sync + 1 register). presetn clears them immediately.
- A DELAY write mid-sequence affects the next gap loaded, not the current countdown.
- SEQCNT increment and a CLR write in the same cycle: clear wins, result 0.
- A sys_rst_n pulse shorter than 2 pclk may be missed. This is permitted.

Optional Feature:
- Macro: APB_RST_SEQ_MASK_EN.
- Defined:
  - Adds register 0x10 MASK [N_DOM-1:0], RW, reset 0.
  - A domain whose MASK bit is 1 is held low during and after sequencing. Its slot still consumes D cycles, so the timing of the other domains is unchanged.
  - Clearing a MASK bit while in DONE releases that domain on the next cycle.
  - STATUS reflects the actual outputs.
- Not defined: 0x10 reads 0, writes are ignored, no mask logic is synthesised.

Test Plan:
- Reset check: presetn low, then high with sys_rst_n=0 -> dom_rst_n=0, STATUS state=0, SEQCNT=0, DELAY reads 16.
- Normal sequence: write DELAY=4, N_DOM=4, raise sys_rst_n -> dom_rst_n goes 0001/0011/0111/1111 at exactly 4/8/12/16 cycles after sync_n rises; SEQCNT reads 1; state=2.
- DELAY=0 -> one domain released per cycle (D=1); all high 4 cycles after sync_n rises.
- Abort mid-sequence: drop sys_rst_n after domain1 releases -> all dom_rst_n 0 within 3 cycles, state=0, SEQCNT unchanged. Re-raise -> full sequence restarts from domain0.
- APB: read 0x20 returns 0; write 0x04 has no effect. Write CLR in the same cycle as a sequence completes -> SEQCNT=0.
- With APB_RST_SEQ_MASK_EN: MASK=0x2, DELAY=2 -> domains 0, 2, 3 release at 2/6/8 and domain1 stays 0. Write MASK=0 in DONE -> domain1 rises next cycle.
